// File: rtl/decode_queue.sv
// Decode stage: decodes fetched instructions and buffers the bundles in a DEPTH-entry FIFO.
// Optional illegal-opcode flagging is compiled in with `define DECODE_ILLEGAL_CHECK_EN.
module decode_queue #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DWIDTH-1:0]       insn_i,
  input  logic [AWIDTH-1:0]       pc_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [AWIDTH-1:0]       pc_o,
  output logic [DWIDTH-1:0]       insn_o,
  output logic [6:0]              opcode_o,
  output logic [4:0]              rd_o,
  output logic [4:0]              rs1_o,
  output logic [4:0]              rs2_o,
  output logic [2:0]              funct3_o,
  output logic [6:0]              funct7_o,
  output logic [4:0]              shamt_o,
  output logic [DWIDTH-1:0]       imm_o,
  output logic                    illegal_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push, pop;

  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] insn_mem [DEPTH];
  logic [DWIDTH-1:0] imm_mem  [DEPTH];

  logic [31:0]       imm32;
  logic [DWIDTH-1:0] imm_in;
  logic [DWIDTH-1:0] head_insn;

  assign in_ready_o  = (count_q != CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign count_o     = count_q;

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  // Immediate is built as a 32-bit RISC-V value, then sign-extended to DWIDTH.
  always_comb begin
    imm32 = '0;
    case (insn_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        imm32 = {{20{insn_i[31]}}, insn_i[31:20]};
      OP_STORE:
        imm32 = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      OP_BRANCH:
        imm32 = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {insn_i[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
    imm_in = DWIDTH'($signed(imm32));
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; out_valid_o gates everything it feeds.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_i;
      insn_mem[wr_ptr_q] <= insn_i;
      imm_mem[wr_ptr_q]  <= imm_in;
    end
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic ill_in;
  logic ill_mem [DEPTH];

  always_comb begin
    ill_in = 1'b1;
    if (insn_i[1:0] == 2'b11) begin
      case (insn_i[6:0])
        OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
        OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: ill_in = 1'b0;
        default: ill_in = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) ill_mem[wr_ptr_q] <= ill_in;
  end

  assign illegal_o = out_valid_o && ill_mem[rd_ptr_q];
`else
  assign illegal_o = 1'b0;
`endif

  assign head_insn = insn_mem[rd_ptr_q];

  always_comb begin
    pc_o     = '0;
    insn_o   = '0;
    imm_o    = '0;
    opcode_o = '0;
    rd_o     = '0;
    rs1_o    = '0;
    rs2_o    = '0;
    funct3_o = '0;
    funct7_o = '0;
    shamt_o  = '0;
    if (out_valid_o) begin
      pc_o     = pc_mem[rd_ptr_q];
      insn_o   = head_insn;
      imm_o    = imm_mem[rd_ptr_q];
      opcode_o = head_insn[6:0];
      rd_o     = head_insn[11:7];
      rs1_o    = head_insn[19:15];
      rs2_o    = head_insn[24:20];
      funct3_o = head_insn[14:12];
      funct7_o = head_insn[31:25];
      shamt_o  = head_insn[24:20];
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed vector table, random traffic against
// a queue-based reference model, and an asynchronous mid-cycle reset.
module tb_decode_queue;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [DW-1:0] insn_i, insn_o, imm_o;
  logic [AW-1:0] pc_i, pc_o;
  logic [6:0]    opcode_o, funct7_o;
  logic [4:0]    rd_o, rs1_o, rs2_o, shamt_o;
  logic [2:0]    funct3_o;
  logic          illegal_o;
  logic [CW-1:0] count_o;

  always #5 clk = ~clk;

  decode_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .insn_i(insn_i), .pc_i(pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o), .shamt_o(shamt_o),
    .imm_o(imm_o), .illegal_o(illegal_o), .count_o(count_o)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Immediate computed with integer arithmetic from the field definitions.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int s, sign, r;
    s    = int'(w);
    sign = (s < 0) ? -1 : 0;
    case (w & 32'h7F)
      32'h13, 32'h03, 32'h67, 32'h73: r = s >>> 20;
      32'h23: r = ((s >>> 20) & ~31) | int'((w >> 7) & 32'h1F);
      32'h63: r = sign * 4096 + int'((w >> 7) & 1) * 2048
                + int'((w >> 25) & 63) * 32 + int'((w >> 8) & 15) * 2;
      32'h37, 32'h17: r = int'(w & 32'hFFFFF000);
      32'h6F: r = sign * 1048576 + int'((w >> 12) & 255) * 4096
                + int'((w >> 20) & 1) * 2048 + int'((w >> 21) & 1023) * 2;
      default: r = 0;
    endcase
    return 32'(r);
  endfunction

  function automatic logic ref_ill(input logic [31:0] w);
    logic [31:0] op;
    op = w & 32'h7F;
    if (!ILL_EN) return 1'b0;
    if ((w & 32'h3) != 32'h3) return 1'b1;
    return !(op inside {32'h33, 32'h13, 32'h03, 32'h23, 32'h63, 32'h6F,
                        32'h67, 32'h37, 32'h17, 32'h0F, 32'h73});
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;
  ent_t mq[$];

  task automatic check_model(input string tag);
    logic [31:0] w, p;
    logic        v;
    w = '0; p = '0;
    v = (mq.size() > 0);
    if (v) begin w = mq[0].insn; p = mq[0].pc; end
    chk({tag, ".valid"},  64'(out_valid_o), 64'(v));
    chk({tag, ".ready"},  64'(in_ready_o),  64'(mq.size() != DEPTH));
    chk({tag, ".count"},  64'(count_o),     64'(mq.size()));
    chk({tag, ".pc"},     64'(pc_o),        64'(p));
    chk({tag, ".insn"},   64'(insn_o),      64'(w));
    chk({tag, ".opcode"}, 64'(opcode_o),    64'(w & 32'h7F));
    chk({tag, ".rd"},     64'(rd_o),        64'((w >> 7) & 32'h1F));
    chk({tag, ".rs1"},    64'(rs1_o),       64'((w >> 15) & 32'h1F));
    chk({tag, ".rs2"},    64'(rs2_o),       64'((w >> 20) & 32'h1F));
    chk({tag, ".funct3"}, 64'(funct3_o),    64'((w >> 12) & 32'h7));
    chk({tag, ".funct7"}, 64'(funct7_o),    64'(w >> 25));
    chk({tag, ".shamt"},  64'(shamt_o),     64'((w >> 20) & 32'h1F));
    chk({tag, ".imm"},    64'(imm_o),       64'(v ? ref_imm(w) : 32'h0));
    chk({tag, ".ill"},    64'(illegal_o),   64'(v ? ref_ill(w) : 1'b0));
  endtask

  typedef struct {
    logic          iv, rdy, fl;
    logic [31:0]   insn, pc;
    logic          ov;
    logic [CW-1:0] cnt;
    logic          ir;
    logic [31:0]   epc, eimm;
    logic [4:0]    erd;
    logic          eill;
  } vec_t;
  vec_t vecs[13];

  logic [6:0] ops[13];

  function automatic logic [31:0] gen_insn();
    logic [31:0] r;
    int unsigned k;
    r = $urandom();
    k = $urandom_range(0, 14);
    if (k < 13) return {r[31:7], ops[k]};
    return r;
  endfunction

  initial begin
    logic push, pop;

    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
            7'h37, 7'h17, 7'h0F, 7'h73, 7'h7F, 7'h0B};

    //          iv    rdy   fl    insn          pc            ov    cnt   ir    epc           eimm          erd    eill
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00500093, 32'h1000, 1'b1, 2'd1, 1'b1, 32'h1000, 32'h00000005, 5'd1,  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'hFE112E23, 32'h1004, 1'b1, 2'd2, 1'b0, 32'h1000, 32'h00000005, 5'd1,  1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'hFE000EE3, 32'h1008, 1'b1, 2'd1, 1'b1, 32'h1004, 32'hFFFFFFFC, 5'd28, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'hFE000EE3, 32'h1008, 1'b1, 2'd2, 1'b0, 32'h1004, 32'hFFFFFFFC, 5'd28, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h0000, 1'b1, 2'd1, 1'b1, 32'h1008, 32'hFFFFFFFC, 5'd29, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h0000, 1'b0, 2'd0, 1'b1, 32'h0000, 32'h00000000, 5'd0,  1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h12345037, 32'h100C, 1'b1, 2'd1, 1'b1, 32'h100C, 32'h12345000, 5'd0,  1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0080006F, 32'h1010, 1'b1, 2'd1, 1'b1, 32'h1010, 32'h00000008, 5'd0,  1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h12345037, 32'h1014, 1'b1, 2'd1, 1'b1, 32'h1014, 32'h12345000, 5'd0,  1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h00500093, 32'h1018, 1'b1, 2'd2, 1'b0, 32'h1014, 32'h12345000, 5'd0,  1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h00500093, 32'h101C, 1'b0, 2'd0, 1'b1, 32'h0000, 32'h00000000, 5'd0,  1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0000007F, 32'h101C, 1'b1, 2'd1, 1'b1, 32'h101C, 32'h00000000, 5'd0,  ILL_EN};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h0000, 1'b0, 2'd0, 1'b1, 32'h0000, 32'h00000000, 5'd0,  1'b0};

    rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    insn_i = '0; pc_i = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset.valid", 64'(out_valid_o), 64'(0));
    chk("reset.ready", 64'(in_ready_o),  64'(1));
    chk("reset.count", 64'(count_o),     64'(0));
    chk("reset.pc",    64'(pc_o),        64'(0));
    chk("reset.imm",   64'(imm_o),       64'(0));
    chk("reset.ill",   64'(illegal_o),   64'(0));
    #9 rst = 1'b0;
    @(posedge clk); #1;

    for (int unsigned i = 0; i < 13; i++) begin
      in_valid_i  = vecs[i].iv;
      out_ready_i = vecs[i].rdy;
      flush_i     = vecs[i].fl;
      insn_i      = vecs[i].insn;
      pc_i        = vecs[i].pc;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.valid", i), 64'(out_valid_o), 64'(vecs[i].ov));
      chk($sformatf("vec%0d.count", i), 64'(count_o),     64'(vecs[i].cnt));
      chk($sformatf("vec%0d.ready", i), 64'(in_ready_o),  64'(vecs[i].ir));
      chk($sformatf("vec%0d.pc", i),    64'(pc_o),        64'(vecs[i].epc));
      chk($sformatf("vec%0d.imm", i),   64'(imm_o),       64'(vecs[i].eimm));
      chk($sformatf("vec%0d.rd", i),    64'(rd_o),        64'(vecs[i].erd));
      chk($sformatf("vec%0d.ill", i),   64'(illegal_o),   64'(vecs[i].eill));
    end

    mq.delete();
    for (int unsigned c = 0; c < 400; c++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 19) == 0);
      insn_i      = gen_insn();
      pc_i        = $urandom();
      push = in_valid_i && (mq.size() < DEPTH) && !flush_i;
      pop  = (mq.size() > 0) && out_ready_i && !flush_i;
      @(posedge clk); #1;
      if (flush_i) mq.delete();
      else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back('{pc_i, insn_i});
      end
      check_model("rand");
    end

    flush_i = 1'b0; out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int unsigned c = 0; c < 2; c++) begin
      insn_i = gen_insn();
      pc_i   = $urandom();
      push   = (mq.size() < DEPTH);
      @(posedge clk); #1;
      if (push) mq.push_back('{pc_i, insn_i});
    end
    in_valid_i = 1'b0;
    check_model("prefill");
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    mq.delete();
    check_model("async_rst");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_model("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Next-generation decode stage: fully decodes each fetched instruction (fields, shift amount, sign-extended immediate) and buffers the decoded bundles in a parametrised-depth FIFO.
- Sits between fetch and execute and decouples them with valid/ready handshakes on both sides.
- Supports pipeline flush on branch/jump redirect.
- Optional illegal-instruction detection.

Parameters:
- DWIDTH, 32: instruction/data width; immediates sign-extend to DWIDTH.
- AWIDTH, 32: PC width.
- DEPTH, 2: FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush_i  input  1  synchronous flush; discards all queued entries
- in_valid_i  input  1  fetch presents an instruction
- in_ready_o  output  1  queue can accept an instruction
- insn_i  input  DWIDTH  instruction word
- pc_i  input  AWIDTH  instruction PC
- out_valid_o  output  1  head entry valid
- out_ready_i  input  1  execute consumes the head entry
- pc_o  output  AWIDTH  head PC
- insn_o  output  DWIDTH  head instruction
- opcode_o  output  7  insn[6:0]
- rd_o  output  5  insn[11:7]
- rs1_o  output  5  insn[19:15]
- rs2_o  output  5  insn[24:20]
- funct3_o  output  3  insn[14:12]
- funct7_o  output  7  insn[31:25]
- shamt_o  output  5  insn[24:20]
- imm_o  output  DWIDTH  decoded immediate
- illegal_o  output  1  head instruction illegal (see Optional Feature)
- count_o  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous and active-high on rst.
  - Reset clears read pointer, write pointer and count to 0.
  - Reset forces out_valid_o=0 and in_ready_o=1.
  - Reset forces all data outputs to 0. Storage contents need not be reset.
- Push: in_valid_i && in_ready_o && !flush_i. The decoded bundle is written at the write pointer and the pointer advances modulo DEPTH.
- Pop: out_valid_o && out_ready_i && !flush_i. The read pointer advances modulo DEPTH.
- Handshake ports:
  - in_ready_o = (count != DEPTH), registered-state only. No combinational path from out_ready_i.
  - out_valid_o = (count != 0).
- Latency: an instruction accepted at edge N appears at the outputs after edge N (one cycle). There is no bypass from input to output.
- Simultaneous push and pop:
  - Count is unchanged.
  - When count==DEPTH, in_ready_o=0, so no push occurs that cycle.
  - When count==1, the head moves to the new entry.
- Flush:
  - At the edge where flush_i=1, pointers and count go to 0.
  - Any push or pop in that cycle is ignored.
  - out_valid_o=0 the following cycle.
  - Flush has priority over push and pop.
- Data outputs with out_valid_o=0: all data outputs, including illegal_o, are driven 0.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; count disambiguates full from empty.
- Decode is combinational on insn_i at push time; the stored bundle is {pc, insn, imm, illegal}. Register fields are sliced from the stored insn. Immediate rules, keyed by opcode:
  - I-type (0010011, 0000011, 1100111, 1110011): sext(insn[31:20]).
  - S-type (0100011): sext({insn[31:25], insn[11:7]}).
  - B-type (1100011): sext({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}).
  - U-type (0110111, 0010111): {insn[31:12], 12'b0}.
  - J-type (1101111): sext({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}).
  - All other opcodes, including R-type 0110011 and 0001111: imm = 0.
- Mid-operation reset: an asynchronous assertion clears state immediately, independent of clk.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHECK_EN.
- Defined:
  - illegal is computed at push and stored with the entry.
  - illegal=1 when insn[1:0] != 2'b11, or when the opcode is outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011}.
  - illegal_o reflects the head entry. An illegal entry is still queued and popped normally.
- Undefined:
  - No illegal storage bit is instantiated.
  - illegal_o is tied 0.

Test Plan:
- Reset, then push insn 32'h00500093 (addi x1,x0,5) at pc 32'h1000 with out_ready_i=0 -> next cycle out_valid_o=1, rd_o=1, rs1_o=0, imm_o=32'h5, pc_o=32'h1000, count_o=1.
- Push sw 32'hFE112E23, then beq 32'hFE000EE3, with out_ready_i=0 -> count_o=2, in_ready_o=0; the second in_valid_i is held and not accepted. Pop -> imm_o=32'hFFFFFFFC (S-type). Next pop -> imm_o=32'hFFFFFFFC (B-type -4).
- Continuous streaming (in_valid_i=1, out_ready_i=1) of lui 32'h12345037, then jal 32'h0080006F -> one output per cycle with no bubbles. imm_o values are 32'h12345000, then 32'h8. Pointers wrap past DEPTH.
- Queue full, then flush_i=1 together with in_valid_i=1 and out_ready_i=1 -> next cycle count_o=0, out_valid_o=0, all data outputs 0, in_ready_o=1.
- Assert rst asynchronously mid-stream (between edges) -> outputs 0 and in_ready_o=1 immediately, without waiting for a clk edge.
- With DECODE_ILLEGAL_CHECK_EN defined, push 32'h0000007F (opcode 1111111) -> illegal_o=1 at the head, imm_o=0. Without the macro -> illegal_o=0.
